mips_program_loader: RTL and testbench



---
 rtl/mips_loader_pkg.sv | 20 ++
 rtl/mips_loader_word_assembler.sv | 33 +++
 rtl/mips_program_loader.sv | 175 +++++++++++++++++
 tb/tb_mips_program_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared state encoding and constants for the MIPS program loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package mips_loader_pkg;

    localparam int          DEFAULT_INST_MEM_SIZE = 64;
    localparam logic [31:0] HALT_WORD             = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        ACK_BYTE  = 3'd2,
        WRITE     = 3'd3,
        FINISH    = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,
        CHECK     = 3'd5
`endif
    } loader_state_t;

endpackage

// File: rtl/mips_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter;
// o_word_complete flags that the most recent byte was the 4th of a word.
module mips_loader_word_assembler #(
    parameter int DATA_BITS = 8,
    parameter int NBITS     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic [DATA_BITS-1:0] i_byte,
    input  logic                 i_byte_valid,
    output logic [NBITS-1:0]     o_word,
    output logic                 o_word_complete
);

    logic [1:0] byte_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_word          <= '0;
            byte_count      <= '0;
            o_word_complete <= 1'b0;
        end else if (i_clear) begin
            byte_count      <= '0;
            o_word_complete <= 1'b0;
        end else if (i_byte_valid) begin
            o_word          <= {o_word[NBITS-DATA_BITS-1:0], i_byte};
            byte_count      <= byte_count + 2'd1;
            o_word_complete <= (byte_count == 2'd3);
        end
    end

endmodule

// File: rtl/mips_program_loader.sv
// Loads a program from the UART into instruction memory, one 32-bit word per
// four bytes, until HALT_WORD. Optional trailing checksum byte: LOADER_CHECKSUM_EN.
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int  DATA_BITS     = 8,
    parameter int  NBITS         = 32,
    parameter int  INST_MEM_SIZE = DEFAULT_INST_MEM_SIZE,
    localparam int ADDR_BITS     = $clog2(INST_MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    output logic                 o_uart_rx_reset,
    output logic                 o_imem_we,
    output logic [ADDR_BITS-1:0] o_imem_addr,
    output logic [NBITS-1:0]     o_imem_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [ADDR_BITS:0]   o_word_count
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(INST_MEM_SIZE - 1);
    localparam logic [NBITS-1:0]     HALT      = NBITS'(HALT_WORD);

    loader_state_t          state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [ADDR_BITS:0]     word_count_q;
    logic                   error_q;
    logic [NBITS-1:0]       asm_word;
    logic                   word_complete;
    logic                   start_accept;
    logic                   byte_valid;
    logic                   is_halt;

    assign start_accept = (state_q == IDLE) && i_start;
    assign byte_valid   = (state_q == WAIT_BYTE) && i_uart_rx_ready;
    assign is_halt      = (asm_word == HALT);

    mips_loader_word_assembler #(
        .DATA_BITS (DATA_BITS),
        .NBITS     (NBITS)
    ) u_word_assembler (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (start_accept),
        .i_byte          (i_uart_rx_data),
        .i_byte_valid    (byte_valid),
        .o_word          (asm_word),
        .o_word_complete (word_complete)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_BITS-1:0] checksum_q;
    logic                 check_seen_q;

    // check_seen_q steers the shared ACK_BYTE state to FINISH after the checksum byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_q   <= '0;
            check_seen_q <= 1'b0;
        end else if (start_accept) begin
            checksum_q   <= '0;
            check_seen_q <= 1'b0;
        end else begin
            if (byte_valid)
                checksum_q <= checksum_q ^ i_uart_rx_data;
            if ((state_q == CHECK) && i_uart_rx_ready)
                check_seen_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_start) state_d = WAIT_BYTE;
            WAIT_BYTE: if (i_uart_rx_ready) state_d = ACK_BYTE;
            ACK_BYTE: begin
`ifdef LOADER_CHECKSUM_EN
                if (check_seen_q)
                    state_d = FINISH;
                else
`endif
                if (word_complete)
                    state_d = WRITE;
                else
                    state_d = WAIT_BYTE;
            end
            WRITE: begin
                if (is_halt)
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = FINISH;
`endif
                else if (addr_q == LAST_ADDR)
                    state_d = FINISH;
                else
                    state_d = WAIT_BYTE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK:     if (i_uart_rx_ready) state_d = ACK_BYTE;
`endif
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        o_uart_rx_reset = 1'b0;
        o_imem_we       = 1'b0;
        o_busy          = 1'b1;
        o_done          = 1'b0;
        case (state_q)
            IDLE: begin
                o_uart_rx_reset = 1'b1;
                o_busy          = 1'b0;
            end
            ACK_BYTE: o_uart_rx_reset = 1'b1;
            WRITE:    o_imem_we       = 1'b1;
            FINISH:   o_done          = 1'b1;
            default:  ;
        endcase
    end

    // Address saturates at the last word so an overflowing load never wraps to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q       <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        addr_q       <= '0;
                        word_count_q <= '0;
                        error_q      <= 1'b0;
                    end
                end
                WRITE: begin
                    word_count_q <= word_count_q + 1'b1;
                    if (addr_q != LAST_ADDR)
                        addr_q <= addr_q + 1'b1;
                    else if (!is_halt)
                        error_q <= 1'b1;
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (i_uart_rx_ready && (i_uart_rx_data != checksum_q))
                        error_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_imem_addr  = addr_q;
    assign o_imem_data  = asm_word;
    assign o_error      = error_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Scoreboard bench for mips_program_loader: expected writes are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_mips_program_loader;

    localparam int DATA_BITS     = 8;
    localparam int NBITS         = 32;
    localparam int INST_MEM_SIZE = 64;
    localparam int ADDR_BITS     = 6;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 i_start = 1'b0;
    logic                 i_uart_rx_ready = 1'b0;
    logic [DATA_BITS-1:0] i_uart_rx_data = '0;
    logic                 o_uart_rx_reset;
    logic                 o_imem_we;
    logic [ADDR_BITS-1:0] o_imem_addr;
    logic [NBITS-1:0]     o_imem_data;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;
    logic [ADDR_BITS:0]   o_word_count;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [NBITS-1:0]     data;
    } wr_t;

    wr_t                  exp_q[$];
    wr_t                  mon_e;
    logic [ADDR_BITS-1:0] exp_addr = '0;
    logic [7:0]           tb_xor = '0;
    int                   checks = 0;
    int                   failures = 0;
    int                   done_count = 0;
    int                   rx_high = 0;
    int                   d0;
    int                   expected_rx;

    mips_program_loader #(
        .DATA_BITS     (DATA_BITS),
        .NBITS         (NBITS),
        .INST_MEM_SIZE (INST_MEM_SIZE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_uart_rx_ready (i_uart_rx_ready),
        .i_uart_rx_data  (i_uart_rx_data),
        .o_uart_rx_reset (o_uart_rx_reset),
        .o_imem_we       (o_imem_we),
        .o_imem_addr     (o_imem_addr),
        .o_imem_data     (o_imem_data),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_word_count    (o_word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_done === 1'b1) done_count++;
        if (o_busy === 1'b1 && o_uart_rx_reset === 1'b1) rx_high++;
        if (o_imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr %0h data %0h with no write expected",
                         o_imem_addr, o_imem_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 64'(o_imem_addr), 64'(mon_e.addr));
                check("write_data", 64'(o_imem_data), 64'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start  = 1'b0;
        tb_xor   = '0;
        exp_addr = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit accepted = 1'b0;
        i_uart_rx_data  = b;
        i_uart_rx_ready = 1'b1;
        tb_xor = tb_xor ^ b;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (o_busy && o_uart_rx_reset) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: byte %0h not acknowledged in 20 cycles", b);
        end
        if (!hold) begin
            i_uart_rx_ready = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit push, input bit hold);
        if (push) begin
            exp_q.push_back(wr_t'{addr: exp_addr, data: w});
            exp_addr = exp_addr + 1'b1;
        end
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], hold);
    endtask

    task automatic end_load();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = tb_xor;
        send_byte(c, 1'b0);
`endif
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (!o_busy) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        if (!idle) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout: o_busy still 1 after 50 cycles", name);
        end
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_reset"},   64'(o_uart_rx_reset), 64'd1);
        check({tag, "_imem_we"},    64'(o_imem_we),       64'd0);
        check({tag, "_imem_addr"},  64'(o_imem_addr),     64'd0);
        check({tag, "_imem_data"},  64'(o_imem_data),     64'd0);
        check({tag, "_busy"},       64'(o_busy),          64'd0);
        check({tag, "_done"},       64'(o_done),          64'd0);
        check({tag, "_error"},      64'(o_error),         64'd0);
        check({tag, "_word_count"}, 64'(o_word_count),    64'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Basic program: one instruction then HALT
        d0 = done_count;
        do_start();
        send_word(32'h2008_0005, 1'b1, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        end_load();
        wait_idle("basic");
        check("basic_word_count", 64'(o_word_count), 64'd2);
        check("basic_error",      64'(o_error),      64'd0);
        check("basic_done",       64'(done_count - d0), 64'd1);
        check("basic_addr",       64'(o_imem_addr),  64'd2);
        check("basic_pending",    64'(exp_q.size()), 64'd0);

        // Receiver ready held high throughout
        d0 = done_count;
        do_start();
        rx_high = 0;
        send_word(32'h0102_0304, 1'b1, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b1);
        i_uart_rx_ready = 1'b0;
        end_load();
        wait_idle("hold");
`ifdef LOADER_CHECKSUM_EN
        expected_rx = 9;
`else
        expected_rx = 8;
`endif
        check("hold_rx_reset_cycles", 64'(rx_high), 64'(expected_rx));
        check("hold_word_count",      64'(o_word_count), 64'd2);
        check("hold_done",            64'(done_count - d0), 64'd1);

        // Overflow: 64 non-halt words fill memory and flag an error
        d0 = done_count;
        do_start();
        for (int i = 0; i < INST_MEM_SIZE; i++) send_word(32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        wait_idle("overflow");
        check("overflow_error",      64'(o_error),      64'd1);
        check("overflow_word_count", 64'(o_word_count), 64'd64);
        check("overflow_addr",       64'(o_imem_addr),  64'd63);
        check("overflow_done",       64'(done_count - d0), 64'd1);
        check("overflow_pending",    64'(exp_q.size()), 64'd0);
        i_uart_rx_data  = 8'h55;
        i_uart_rx_ready = 1'b1;
        repeat (10) tick();
        i_uart_rx_ready = 1'b0;
        check("overflow_stays_idle", 64'(o_busy), 64'd0);

        // i_start mid-load is ignored
        do_start();
        check("restart_error_cleared", 64'(o_error),      64'd0);
        check("restart_word_count",    64'(o_word_count), 64'd0);
        send_word(32'h1122_3344, 1'b1, 1'b0);
        exp_q.push_back(wr_t'{addr: exp_addr, data: 32'hAABB_CCDD});
        exp_addr = exp_addr + 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("ignored_start_addr",  64'(o_imem_addr),  64'd1);
        check("ignored_start_count", 64'(o_word_count), 64'd1);
        check("ignored_start_busy",  64'(o_busy),       64'd1);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        end_load();
        wait_idle("ignored_start");
        check("ignored_start_final_count", 64'(o_word_count), 64'd3);

        // Reset after 6 bytes abandons the load
        d0 = done_count;
        do_start();
        send_word(32'h5566_7788, 1'b1, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'h9A, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        check_reset_outputs("midload_reset");
        reset = 1'b1;
        repeat (5) tick();
        check("midload_no_done",  64'(done_count - d0), 64'd0);
        check("midload_pending",  64'(exp_q.size()),    64'd0);
        do_start();
        send_word(32'h0A0B_0C0D, 1'b1, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        end_load();
        wait_idle("after_reset");
        check("after_reset_word_count", 64'(o_word_count), 64'd2);
        check("after_reset_done",       64'(done_count - d0), 64'd1);
        check("after_reset_pending",    64'(exp_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        do_start();
        send_word(32'h0000_0000, 1'b1, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_idle("csum_good");
        check("csum_good_error", 64'(o_error), 64'd0);
        do_start();
        send_word(32'h0000_0000, 1'b1, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_idle("csum_bad");
        check("csum_bad_error", 64'(o_error), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
